// File: rtl/of_stage_fwd.sv
// Operand-fetch stage: register decode, EX/MA forwarding with load-use interlock,
// immediate generation and a valid/ready OF/EX pipeline register with stall counter.
module of_stage_fwd #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RA_IDX = 15,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_valid,
    output logic             o_if_ready,
    input  logic [PC_W-1:0]  i_if_pc,
    input  logic [31:0]      i_if_instr,
    output logic [4:0]       o_cu_opcode,
    output logic             o_cu_imm,
    input  logic             i_cu_is_ret,
    input  logic             i_cu_is_st,
    input  logic             i_cu_is_imm,
    output logic [3:0]       o_rd_addr1,
    output logic [3:0]       o_rd_addr2,
    input  logic [XLEN-1:0]  i_rd_data1,
    input  logic [XLEN-1:0]  i_rd_data2,
    input  logic             i_ex_wr_en,
    input  logic             i_ex_is_ld,
    input  logic [3:0]       i_ex_wr_addr,
    input  logic [XLEN-1:0]  i_ex_wr_data,
    input  logic             i_ma_wr_en,
    input  logic [3:0]       i_ma_wr_addr,
    input  logic [XLEN-1:0]  i_ma_wr_data,
    input  logic             i_flush,
    output logic             o_of_valid,
    input  logic             i_of_ready,
    output logic [PC_W-1:0]  o_of_pc,
    output logic [31:0]      o_of_instr,
    output logic [XLEN-1:0]  o_of_a,
    output logic [XLEN-1:0]  o_of_b,
    output logic [XLEN-1:0]  o_of_op2,
    output logic [CNT_W-1:0] o_of_stall_cnt
);

    localparam logic [3:0] RA_ADDR = 4'(RA_IDX);
    localparam logic       FWD     = (FWD_EN != 0);

    logic            w_use1, w_use2;
    logic            w_ex_hit1, w_ex_hit2, w_ma_hit1, w_ma_hit2;
    logic            w_hazard, w_adv, w_fire;
    logic [XLEN-1:0] w_src1, w_src2, w_imm;
    logic [15:0]     w_imm16;

    logic             r_valid;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_instr;
    logic [XLEN-1:0]  r_a, r_b, r_op2;
    logic [CNT_W-1:0] r_cnt;

    // Decode towards the control unit and register file
    always_comb begin
        o_cu_opcode = 5'd0;
        o_cu_imm    = 1'b0;
        o_rd_addr1  = 4'd0;
        o_rd_addr2  = 4'd0;
        if (i_if_valid) begin
            o_cu_opcode = i_if_instr[31:27];
            o_cu_imm    = i_if_instr[26];
            o_rd_addr1  = i_cu_is_ret ? RA_ADDR : i_if_instr[21:18];
            o_rd_addr2  = i_cu_is_st ? i_if_instr[25:22] : i_if_instr[17:14];
        end
    end

    assign w_use1    = i_if_valid;
    assign w_use2    = i_if_valid && (!i_cu_is_imm || i_cu_is_st);
    assign w_ex_hit1 = i_ex_wr_en && (i_ex_wr_addr == o_rd_addr1);
    assign w_ex_hit2 = i_ex_wr_en && (i_ex_wr_addr == o_rd_addr2);
    assign w_ma_hit1 = i_ma_wr_en && (i_ma_wr_addr == o_rd_addr1);
    assign w_ma_hit2 = i_ma_wr_en && (i_ma_wr_addr == o_rd_addr2);

    // Operand bypass; an EX load cannot forward and is covered by the interlock
    always_comb begin
        w_src1 = i_rd_data1;
        w_src2 = i_rd_data2;
        if (FWD) begin
            if (w_ex_hit1 && !i_ex_is_ld) w_src1 = i_ex_wr_data;
            else if (w_ma_hit1)          w_src1 = i_ma_wr_data;
            if (w_ex_hit2 && !i_ex_is_ld) w_src2 = i_ex_wr_data;
            else if (w_ma_hit2)          w_src2 = i_ma_wr_data;
        end
    end

    always_comb begin
        w_hazard = (w_use1 && w_ex_hit1 && i_ex_is_ld) ||
                   (w_use2 && w_ex_hit2 && i_ex_is_ld);
        if (!FWD) begin
            w_hazard = w_hazard ||
                       (w_use1 && (w_ex_hit1 || w_ma_hit1)) ||
                       (w_use2 && (w_ex_hit2 || w_ma_hit2));
        end
    end

    assign w_imm16 = i_if_instr[15:0];

    always_comb begin
        w_imm = XLEN'(w_imm16);
        case (i_if_instr[17:16])
            2'b00:   w_imm = {{(XLEN-16){w_imm16[15]}}, w_imm16};
            2'b10:   w_imm = XLEN'({w_imm16, 16'h0000});
            default: w_imm = XLEN'(w_imm16);
        endcase
    end

    assign w_adv      = !r_valid || i_of_ready;
    assign o_if_ready = w_adv && !w_hazard && !i_flush;
    assign w_fire     = i_if_valid && o_if_ready;

    // OF/EX register: flush kills, backpressure holds, otherwise bubble or capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op2   <= '0;
            r_cnt   <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_fire;
                if (w_fire) begin
                    r_pc    <= i_if_pc;
                    r_instr <= i_if_instr;
                    r_a     <= w_src1;
                    r_b     <= i_cu_is_imm ? w_imm : w_src2;
                    r_op2   <= w_src2;
                end
            end
            if (i_if_valid && w_hazard && !i_flush && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_of_valid     = r_valid;
    assign o_of_pc        = r_pc;
    assign o_of_instr     = r_instr;
    assign o_of_a         = r_a;
    assign o_of_b         = r_b;
    assign o_of_op2       = r_op2;
    assign o_of_stall_cnt = r_cnt;

endmodule

// File: tb/tb_of_stage_fwd.sv
// Scoreboard bench for of_stage_fwd: expected OF/EX payloads are queued at accept
// and compared on the following cycle; a 3-bit stall counter exposes saturation.
module tb_of_stage_fwd;

    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] op2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, if_valid, if_ready;
    logic [31:0]   if_pc, if_instr;
    logic [4:0]    cu_opcode;
    logic          cu_imm, cu_is_ret, cu_is_st, cu_is_imm;
    logic [3:0]    rd_addr1, rd_addr2;
    logic [31:0]   rd_data1, rd_data2;
    logic          ex_wr_en, ex_is_ld, ma_wr_en, flush, of_valid, of_ready;
    logic [3:0]    ex_wr_addr, ma_wr_addr;
    logic [31:0]   ex_wr_data, ma_wr_data;
    logic [31:0]   of_pc, of_instr, of_a, of_b, of_op2;
    logic [CW-1:0] of_stall_cnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    of_stage_fwd #(.XLEN(32), .PC_W(32), .RA_IDX(15), .FWD_EN(1), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(if_ready),
        .i_if_pc(if_pc), .i_if_instr(if_instr), .o_cu_opcode(cu_opcode), .o_cu_imm(cu_imm),
        .i_cu_is_ret(cu_is_ret), .i_cu_is_st(cu_is_st), .i_cu_is_imm(cu_is_imm),
        .o_rd_addr1(rd_addr1), .o_rd_addr2(rd_addr2),
        .i_rd_data1(rd_data1), .i_rd_data2(rd_data2),
        .i_ex_wr_en(ex_wr_en), .i_ex_is_ld(ex_is_ld), .i_ex_wr_addr(ex_wr_addr),
        .i_ex_wr_data(ex_wr_data), .i_ma_wr_en(ma_wr_en), .i_ma_wr_addr(ma_wr_addr),
        .i_ma_wr_data(ma_wr_data), .i_flush(flush), .o_of_valid(of_valid),
        .i_of_ready(of_ready), .o_of_pc(of_pc), .o_of_instr(of_instr),
        .o_of_a(of_a), .o_of_b(of_b), .o_of_op2(of_op2), .o_of_stall_cnt(of_stall_cnt)
    );

    // Register file contents: r3 = 0x10, every other rN = 0x100 + N
    function automatic logic [31:0] gval(input logic [3:0] addr);
        return (addr == 4'd3) ? 32'h10 : (32'h100 + 32'(addr));
    endfunction

    assign rd_data1 = gval(rd_addr1);
    assign rd_data2 = gval(rd_addr2);

    function automatic logic [31:0] mk_imm(input logic [3:0] rd, input logic [3:0] rs1,
                                           input logic [1:0] mode, input logic [15:0] imm);
        return {5'h02, 1'b1, rd, rs1, mode, imm};
    endfunction

    function automatic logic [31:0] mk_reg(input logic [3:0] rd, input logic [3:0] rs1,
                                           input logic [3:0] rs2);
        return {5'h01, 1'b0, rd, rs1, rs2, 14'h0};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock: check acceptance, queue the expected payload on accept, compare after the edge
    task automatic cycle(input logic exp_rdy, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] eop2);
        exp_t e;
        logic pushed;
        #1;
        check_eq("if_ready", 64'(if_ready), 64'(exp_rdy));
        pushed = if_valid && exp_rdy;
        if (pushed) q.push_back('{pc: if_pc, instr: if_instr, a: ea, b: eb, op2: eop2});
        step();
        if (pushed) begin
            e = q.pop_front();
            check_eq("of_valid", 64'(of_valid), 64'(1));
            check_eq("of_pc", 64'(of_pc), 64'(e.pc));
            check_eq("of_instr", 64'(of_instr), 64'(e.instr));
            check_eq("of_a", 64'(of_a), 64'(e.a));
            check_eq("of_b", 64'(of_b), 64'(e.b));
            check_eq("of_op2", 64'(of_op2), 64'(e.op2));
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = 32'hFFFF_FFFF;
        cu_is_ret = 1'b0; cu_is_st = 1'b0; cu_is_imm = 1'b0;
        ex_wr_en = 1'b0; ex_is_ld = 1'b0; ex_wr_addr = '0; ex_wr_data = '0;
        ma_wr_en = 1'b0; ma_wr_addr = '0; ma_wr_data = '0;
        flush = 1'b0; of_ready = 1'b1;

        // Reset and idle decode
        step();
        step();
        check_eq("rst_valid", 64'(of_valid), 64'(0));
        check_eq("rst_cnt", 64'(of_stall_cnt), 64'(0));
        check_eq("rst_a", 64'(of_a), 64'(0));
        check_eq("idle_opcode", 64'(cu_opcode), 64'(0));
        check_eq("idle_addr1", 64'(rd_addr1), 64'(0));
        rst = 1'b0;
        #1;
        check_eq("rel_ready", 64'(if_ready), 64'(1));

        // Immediate modes; rs2 field aliases {mode, imm[15:14]}
        if_valid = 1'b1; cu_is_imm = 1'b1;
        if_pc = 32'h100; if_instr = mk_imm(4'd1, 4'd3, 2'b00, 16'h8001);
        #1;
        check_eq("opcode", 64'(cu_opcode), 64'(5'h02));
        check_eq("cu_imm", 64'(cu_imm), 64'(1));
        cycle(1'b1, 32'h10, 32'hFFFF_8001, 32'h102);
        if_pc = 32'h104; if_instr = mk_imm(4'd1, 4'd3, 2'b01, 16'h8001);
        cycle(1'b1, 32'h10, 32'h0000_8001, 32'h106);
        if_pc = 32'h108; if_instr = mk_imm(4'd1, 4'd3, 2'b10, 16'h8001);
        cycle(1'b1, 32'h10, 32'h8001_0000, 32'h10A);
        if_pc = 32'h10C; if_instr = mk_imm(4'd1, 4'd3, 2'b11, 16'h8001);
        cycle(1'b1, 32'h10, 32'h0000_8001, 32'h10E);

        // Forwarding: EX to rs1, MA to rs2, then EX beating MA on rs1
        cu_is_imm = 1'b0;
        ex_wr_en = 1'b1; ex_wr_addr = 4'd5; ex_wr_data = 32'hAA;
        ma_wr_en = 1'b1; ma_wr_addr = 4'd6; ma_wr_data = 32'hBB;
        if_pc = 32'h110; if_instr = mk_reg(4'd7, 4'd5, 4'd6);
        cycle(1'b1, 32'hAA, 32'hBB, 32'hBB);
        ma_wr_addr = 4'd5; ma_wr_data = 32'hCC;
        if_pc = 32'h114;
        cycle(1'b1, 32'hAA, 32'h106, 32'h106);
        ma_wr_en = 1'b0;

        // Load-use interlock for two cycles, then release
        ex_is_ld = 1'b1; ex_wr_addr = 4'd3; ex_wr_data = 32'hDEAD;
        if_pc = 32'h118; if_instr = mk_reg(4'd7, 4'd3, 4'd4);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, '0, '0);
            check_eq("ld_bubble", 64'(of_valid), 64'(0));
        end
        check_eq("ld_cnt", 64'(of_stall_cnt), 64'(2));
        ex_wr_en = 1'b0;
        cycle(1'b1, 32'h10, 32'h104, 32'h104);
        check_eq("ld_cnt_hold", 64'(of_stall_cnt), 64'(2));

        // Backpressure holds the payload
        of_ready = 1'b0;
        if_pc = 32'h200; if_instr = mk_reg(4'd7, 4'd1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, '0);
            check_eq("bp_valid", 64'(of_valid), 64'(1));
            check_eq("bp_pc", 64'(of_pc), 64'(32'h118));
            check_eq("bp_a", 64'(of_a), 64'(32'h10));
        end
        check_eq("bp_cnt", 64'(of_stall_cnt), 64'(2));
        of_ready = 1'b1;
        cycle(1'b1, 32'h101, 32'h102, 32'h102);

        // Return-address read and store data path
        cu_is_ret = 1'b1;
        if_pc = 32'h204; if_instr = mk_reg(4'd0, 4'd2, 4'd1);
        #1;
        check_eq("ret_addr1", 64'(rd_addr1), 64'(15));
        cycle(1'b1, 32'h10F, 32'h101, 32'h101);
        cu_is_ret = 1'b0; cu_is_st = 1'b1; cu_is_imm = 1'b1;
        if_pc = 32'h208; if_instr = mk_imm(4'd9, 4'd1, 2'b01, 16'h0004);
        #1;
        check_eq("st_addr2", 64'(rd_addr2), 64'(9));
        cycle(1'b1, 32'h101, 32'h4, 32'h109);
        cu_is_st = 1'b0; cu_is_imm = 1'b0;

        // Flush during a load-use hazard: flush wins, counter frozen
        ex_wr_en = 1'b1; ex_is_ld = 1'b1; ex_wr_addr = 4'd3;
        if_pc = 32'h20C; if_instr = mk_reg(4'd7, 4'd3, 4'd4);
        flush = 1'b1;
        cycle(1'b0, '0, '0, '0);
        check_eq("fl_valid", 64'(of_valid), 64'(0));
        check_eq("fl_cnt", 64'(of_stall_cnt), 64'(2));
        flush = 1'b0;
        cycle(1'b0, '0, '0, '0);
        check_eq("fl_cnt_after", 64'(of_stall_cnt), 64'(3));

        // Reset mid-stall, then accept right after release
        rst = 1'b1;
        step();
        check_eq("mid_rst_cnt", 64'(of_stall_cnt), 64'(0));
        check_eq("mid_rst_pc", 64'(of_pc), 64'(0));
        rst = 1'b0; ex_wr_en = 1'b0;
        cycle(1'b1, 32'h10, 32'h104, 32'h104);

        // Counter saturates at all-ones
        ex_wr_en = 1'b1;
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, '0, '0);
        check_eq("sat_cnt", 64'(of_stall_cnt), 64'(7));
        check_eq("sat_bubble", 64'(of_valid), 64'(0));

        if_valid = 1'b0; ex_wr_en = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/of_stage_fwd.md
Name: of_stage_fwd

Overview:
Parametrised operand-fetch stage that sits between the IF/OF and OF/EX boundaries.
- Decodes register addresses and control-unit inputs from the fetched instruction.
- Resolves RAW hazards by forwarding from EX and MA, and interlocks on load-use.
- Builds the ALU operands, including the 4-mode immediate.
- Registers the result into a valid/ready OF/EX pipeline register with flush support and a saturating stall counter.

Parameters:
XLEN, 32, datapath width (>=32).
PC_W, 32, PC width.
RA_IDX, 15, GPR index holding the return address.
FWD_EN, 1, 1 = forward from EX/MA; 0 = stall on any EX/MA destination match.
CNT_W, 16, stall-counter width.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
If_Valid  in  1  IF payload valid
If_Ready  out  1  OF accepts IF payload this cycle
If_Pc  in  PC_W  PC of the fetched instruction
If_Instr  in  32  instruction
Cu_Opcode  out  5  If_Instr[31:27]
Cu_Imm  out  1  If_Instr[26]
Cu_IsRet, Cu_IsSt, Cu_IsImm  in  1 each  control-unit decode (combinational return)
Rd_Addr1, Rd_Addr2  out  4  GPR read addresses
Rd_Data1, Rd_Data2  in  XLEN  GPR read data (combinational)
Ex_WrEn, Ex_IsLd  in  1  EX-stage write pending / EX-stage instruction is a load
Ex_WrAddr  in  4  EX-stage destination register; Ex_WrData  in  XLEN  EX-stage result
Ma_WrEn  in  1  MA-stage write pending; Ma_WrAddr  in  4  MA-stage destination; Ma_WrData  in  XLEN  MA-stage result
Flush  in  1  kill the OF/EX contents
Of_Valid  out  1  OF/EX payload valid; Of_Ready  in  1  EX accepts the payload
Of_Pc  out  PC_W  registered PC; Of_Instr  out  32  registered instruction
Of_A, Of_B, Of_Op2  out  XLEN  operand 1, operand 2 (imm or reg), rs2/store data
Of_StallCnt  out  CNT_W  hazard-stall cycle count

Behaviour:
- Cu_Opcode and Cu_Imm are driven from If_Instr whenever If_Valid = 1, otherwise 0.
- Rd_Addr1 = Cu_IsRet ? RA_IDX : instr[21:18].
- Rd_Addr2 = Cu_IsSt ? instr[25:22] : instr[17:14].
- When If_Valid = 0, Rd_Addr1 and Rd_Addr2 are 0.
- No hardwired-zero register.
- Operand usage:
  - src1 is used whenever If_Valid = 1.
  - src2 is used when !Cu_IsImm or Cu_IsSt.
- Forwarding, per operand, when FWD_EN = 1 (EX has priority over MA):
  - Ex_WrEn && !Ex_IsLd && Ex_WrAddr == addr selects Ex_WrData.
  - Otherwise Ma_WrEn && Ma_WrAddr == addr selects Ma_WrData.
  - Otherwise Rd_Data.
- Hazard: any used operand with Ex_WrEn && Ex_IsLd && address match.
  - When FWD_EN = 0, a hazard is also any used-operand match on (Ex_WrEn, Ex_WrAddr) or (Ma_WrEn, Ma_WrAddr).
- Immediate, selected by instr[17:16] with imm16 = instr[15:0]:
  - 00: sign-extend imm16 to XLEN.
  - 01: zero-extend imm16.
  - 10: imm16 << 16, zero-extended.
  - 11: same as 01.
- Operand outputs:
  - Of_A = src1 value.
  - Of_Op2 = src2 value (the true rs2/rd path, never src1).
  - Of_B = Cu_IsImm ? imm : src2 value.
- Handshake:
  - adv = !Of_Valid || Of_Ready.
  - If_Ready = adv && !hazard && !Flush.
  - Handshake fire = If_Valid && If_Ready.
- Pipeline register (1-cycle latency):
  - Rst: Of_Valid = 0, all Of_* payload = 0, Of_StallCnt = 0.
  - Flush (priority over everything except Rst): Of_Valid <= 0.
  - Else if adv: Of_Valid <= fire, and the payload is captured on fire. On !fire the payload holds and a bubble is inserted.
  - Else (Of_Valid && !Of_Ready): all Of_* hold stable.
- Of_StallCnt increments each cycle with If_Valid && hazard && !Flush && !Rst. It saturates at all-ones and never wraps.
- Simultaneous Flush and hazard: flush wins and the counter does not increment.
- Rst asserted mid-stall clears state at the next edge; the first accept is possible the cycle after Rst deasserts.

Test Plan:
1. Rst high 2 cycles, If_Valid = 0 -> Of_Valid = 0, Of_StallCnt = 0, If_Ready = 1 after release.
2. Immediate op (I = 1, rs1 = 3, Rd_Data1 = 0x10, imm16 = 0x8001, Cu_IsImm = 1), Of_Ready = 1:
   - mod 00 -> next cycle Of_A = 0x10, Of_B = 0xFFFF8001.
   - mod 01 -> Of_B = 0x00008001.
   - mod 10 -> Of_B = 0x80010000.
3. Register op rs1 = 5, rs2 = 6, with Ex_WrEn = 1 (Ex_WrAddr = 5, Ex_WrData = 0xAA) and Ma_WrEn = 1 (Ma_WrAddr = 6, Ma_WrData = 0xBB) -> Of_A = 0xAA, Of_B = Of_Op2 = 0xBB. With Ma_WrAddr = 5 and Ma_WrData = 0xCC, Of_A stays 0xAA.
4. Load-use: Ex_IsLd = 1, Ex_WrAddr = 3, rs1 = 3, held 2 cycles -> If_Ready = 0 and Of_Valid = 0 both cycles, Of_StallCnt = 2. Ex_WrEn drops -> accepted, Of_Valid = 1 next cycle.
5. Backpressure: Of_Valid = 1, Of_Ready = 0 for 3 cycles -> Of_* unchanged, If_Ready = 0, counter unchanged. Of_Ready = 1 -> new payload next cycle. Cu_IsRet = 1 -> Rd_Addr1 = 15. Cu_IsSt = 1 with rd = 9 -> Rd_Addr2 = 9.
6. Flush = 1 while Of_Valid = 1 and a load-use hazard is active -> next cycle Of_Valid = 0, If_Ready = 0 during Flush, Of_StallCnt unchanged.
